// File: rtl/kmkz_wb_pkg.sv
// Shared definitions for the Kamikaze-uRV writeback stage: load funct3 codes,
// FSM state encoding and the W-stage pipeline register layout.
package kmkz_wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        write;
        logic        load;
        logic [2:0]  fun;
        logic [1:0]  addr;
    } wb_stage_t;

endpackage

// File: rtl/kmkz_load_align.sv
// Load data alignment: picks the byte/halfword lane addressed by addr_i and
// sign- or zero-extends it; LW and reserved codes pass the word through.
module kmkz_load_align
    import kmkz_wb_pkg::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[7:0];
        case (addr_i)
            2'd0: byte_sel = data_i[7:0];
            2'd1: byte_sel = data_i[15:8];
            2'd2: byte_sel = data_i[23:16];
            2'd3: byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
        half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
    end

    always_comb begin
        value_o = data_i;
        case (fun_i)
            LB:      value_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     value_o = {24'd0, byte_sel};
            LH:      value_o = {{16{half_sel[15]}}, half_sel};
            LHU:     value_o = {16'd0, half_sel};
            LW:      value_o = data_i;
            default: value_o = data_i;
        endcase
    end

endmodule

// File: rtl/kmkz_writeback.sv
// Writeback stage: registers the X result, waits for load data, drives the
// register-file write / bypass port and stalls upstream while a load is pending.
module kmkz_writeback
    import kmkz_wb_pkg::*;
#(
    parameter int G_LOAD_TIMEOUT = 255,
    parameter int G_CNT_W        = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic        dm_load_done_i,
    input  logic [31:0] dm_data_l_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_store_o,
    output logic        rf_bypass_rd_write_o,
    output logic [31:0] rf_bypass_rd_value_o,
    output logic        w_stall_req_o,
    output logic        w_load_fault_o
);

    localparam logic [G_CNT_W-1:0] TIMEOUT = G_CNT_W'(G_LOAD_TIMEOUT);

    wb_state_e          state_q;
    logic [G_CNT_W-1:0] cnt_q;
    wb_stage_t          stage_q, stage_d;

    logic        we;
    logic        load_pending;
    logic        commit;
    logic        fault;
    logic        stall;
    logic [31:0] load_value;
    logic [31:0] wr_value;

    kmkz_load_align u_align (
        .fun_i   (stage_q.fun),
        .addr_i  (stage_q.addr),
        .data_i  (dm_data_l_i),
        .value_o (load_value)
    );

    assign we           = stage_q.valid && stage_q.write && (stage_q.rd != 5'd0);
    assign load_pending = stage_q.valid && stage_q.load;
    // A load commits only on the cycle its data arrives; everything else commits at once.
    assign commit       = stage_q.load ? dm_load_done_i : 1'b1;
    assign stall        = load_pending && !dm_load_done_i;
    assign fault        = (state_q == LOAD_WAIT) && !dm_load_done_i && (cnt_q == TIMEOUT);
    assign wr_value     = stage_q.load ? load_value : stage_q.value;

    assign rf_rd_o              = stage_q.rd;
    assign rf_rd_value_o        = wr_value;
    assign rf_rd_store_o        = we && commit;
    assign rf_bypass_rd_write_o = we && commit;
    assign rf_bypass_rd_value_o = wr_value;
    assign w_stall_req_o        = stall;
    assign w_load_fault_o       = fault;

    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            stage_d.valid = x_valid_i;
            stage_d.rd    = x_rd_i;
            stage_d.value = x_rd_value_i;
            stage_d.write = x_rd_write_i;
            stage_d.load  = x_load_i;
            stage_d.fun   = x_fun_i;
            stage_d.addr  = x_dm_addr_i;
        end else if (fault) begin
            // Abandon the lost load so the stage cannot retire it later.
            stage_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
            case (state_q)
                IDLE: begin
                    if (stall) begin
                        state_q <= LOAD_WAIT;
                        cnt_q   <= G_CNT_W'(1);
                    end
                end
                LOAD_WAIT: begin
                    if (dm_load_done_i || fault) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + G_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmkz_writeback.sv
// Self-checking bench for kmkz_writeback: scoreboard of expected RF writes,
// one task per scenario, inputs driven 2 time units after posedge, outputs sampled 1 later.
module tb_kmkz_writeback;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic [4:0]  x_rd;
    logic [31:0] x_rd_value;
    logic        x_rd_write;
    logic        x_load;
    logic [2:0]  x_fun;
    logic [1:0]  x_dm_addr;
    logic        dm_done;
    logic [31:0] dm_data;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_store_o;
    logic        rf_bypass_rd_write_o;
    logic [31:0] rf_bypass_rd_value_o;
    logic        w_stall_req_o;
    logic        w_load_fault_o;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    wr_t e;

    always #5 clk = ~clk;

    kmkz_writeback #(
        .G_LOAD_TIMEOUT (4),
        .G_CNT_W        (16)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .x_valid_i            (x_valid),
        .x_rd_i               (x_rd),
        .x_rd_value_i         (x_rd_value),
        .x_rd_write_i         (x_rd_write),
        .x_load_i             (x_load),
        .x_fun_i              (x_fun),
        .x_dm_addr_i          (x_dm_addr),
        .dm_load_done_i       (dm_done),
        .dm_data_l_i          (dm_data),
        .rf_rd_o              (rf_rd_o),
        .rf_rd_value_o        (rf_rd_value_o),
        .rf_rd_store_o        (rf_rd_store_o),
        .rf_bypass_rd_write_o (rf_bypass_rd_write_o),
        .rf_bypass_rd_value_o (rf_bypass_rd_value_o),
        .w_stall_req_o        (w_stall_req_o),
        .w_load_fault_o       (w_load_fault_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        x_valid = 0; x_rd = 0; x_rd_value = 0; x_rd_write = 0;
        x_load = 0; x_fun = 0; x_dm_addr = 0; dm_done = 0; dm_data = 0;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] val,
                         input logic wr, input logic ld, input logic [2:0] fun,
                         input logic [1:0] addr);
        x_valid = v; x_rd = rd; x_rd_value = val; x_rd_write = wr;
        x_load = ld; x_fun = fun; x_dm_addr = addr;
    endtask

    function automatic wr_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1; idle_in();
        next_cycle(); next_cycle(); #1;
        n_checks++;
        if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o, rf_bypass_rd_write_o, rf_bypass_rd_value_o,
             w_stall_req_o, w_load_fault_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got rd=%0d val=%h st=%b stall=%b fault=%b want all 0",
                               rf_rd_o, rf_rd_value_o, rf_rd_store_o, w_stall_req_o, w_load_fault_o);
        end
        next_cycle(); rst = 0; #1;
        next_cycle(); #1;
        n_checks++;
        if ({rf_rd_store_o, rf_bypass_rd_write_o, w_stall_req_o, w_load_fault_o} !== 4'b0) begin
            n_fail++; $display("FAIL post_reset_idle got st=%b byp=%b stall=%b fault=%b want 0",
                               rf_rd_store_o, rf_bypass_rd_write_o, w_stall_req_o, w_load_fault_o);
        end
    endtask

    task automatic test_alu();
        next_cycle();
        drive(1, 5'd5, 32'hDEADBEEF, 1, 0, 3'b000, 2'd0);
        exp_q.push_back(wr_t'{rd: 5'd5, val: 32'hDEADBEEF});
        next_cycle(); idle_in(); #1;
        e = pop_exp();
        n_checks++;
        if (rf_rd_store_o !== 1'b1 || {rf_rd_o, rf_rd_value_o} !== e) begin
            n_fail++; $display("FAIL alu_write got st=%b rd=%0d val=%h want st=1 rd=%0d val=%h",
                               rf_rd_store_o, rf_rd_o, rf_rd_value_o, e.rd, e.val);
        end
        n_checks++;
        if (rf_bypass_rd_write_o !== 1'b1 || rf_bypass_rd_value_o !== e.val || w_stall_req_o !== 1'b0) begin
            n_fail++; $display("FAIL alu_bypass got byp=%b val=%h stall=%b want 1 %h 0",
                               rf_bypass_rd_write_o, rf_bypass_rd_value_o, w_stall_req_o, e.val);
        end
        next_cycle(); #1;
        n_checks++;
        if (rf_rd_store_o !== 1'b0) begin
            n_fail++; $display("FAIL alu_single_pulse got st=%b want 0", rf_rd_store_o);
        end
    endtask

    task automatic test_x0();
        next_cycle();
        drive(1, 5'd0, 32'h12345678, 1, 0, 3'b000, 2'd0);
        for (int c = 0; c < 2; c++) begin
            next_cycle(); idle_in(); #1;
            n_checks++;
            if (rf_rd_store_o !== 1'b0 || rf_bypass_rd_write_o !== 1'b0) begin
                n_fail++; $display("FAIL x0_no_write cyc=%0d got st=%b byp=%b want 0 0",
                                   c, rf_rd_store_o, rf_bypass_rd_write_o);
            end
        end
    endtask

    task automatic test_same_cycle_load(input logic [2:0] fun, input logic [1:0] addr,
                                        input logic [31:0] data, input logic [31:0] expv);
        next_cycle();
        drive(1, 5'd6, 32'h0, 1, 1, fun, addr);
        exp_q.push_back(wr_t'{rd: 5'd6, val: expv});
        next_cycle(); idle_in(); dm_done = 1; dm_data = data; #1;
        e = pop_exp();
        n_checks++;
        if (rf_rd_store_o !== 1'b1 || rf_bypass_rd_write_o !== 1'b1 || {rf_rd_o, rf_rd_value_o} !== e
            || w_stall_req_o !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_load fun=%b addr=%0d got st=%b byp=%b val=%h stall=%b want 1 1 %h 0",
                               fun, addr, rf_rd_store_o, rf_bypass_rd_write_o, rf_rd_value_o, w_stall_req_o, e.val);
        end
        next_cycle(); dm_done = 0; #1;
        n_checks++;
        if (rf_rd_store_o !== 1'b0 || w_stall_req_o !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_after fun=%b got st=%b stall=%b want 0 0",
                               fun, rf_rd_store_o, w_stall_req_o);
        end
    endtask

    task automatic test_delayed_load();
        next_cycle();
        drive(1, 5'd7, 32'h0, 1, 1, 3'b010, 2'd3);
        exp_q.push_back(wr_t'{rd: 5'd7, val: 32'h11223344});
        // Next instruction is presented and held by upstream throughout the stall.
        next_cycle();
        drive(1, 5'd9, 32'h000000A5, 1, 0, 3'b000, 2'd0);
        exp_q.push_back(wr_t'{rd: 5'd9, val: 32'h000000A5});
        #1;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin next_cycle(); #1; end
            n_checks++;
            if (w_stall_req_o !== 1'b1 || rf_rd_store_o !== 1'b0) begin
                n_fail++; $display("FAIL delayed_wait cyc=%0d got stall=%b st=%b want 1 0",
                                   c, w_stall_req_o, rf_rd_store_o);
            end
        end
        next_cycle(); dm_done = 1; dm_data = 32'h11223344; #1;
        e = pop_exp();
        n_checks++;
        if (rf_rd_store_o !== 1'b1 || {rf_rd_o, rf_rd_value_o} !== e || w_stall_req_o !== 1'b0) begin
            n_fail++; $display("FAIL delayed_done got st=%b rd=%0d val=%h stall=%b want 1 %0d %h 0",
                               rf_rd_store_o, rf_rd_o, rf_rd_value_o, w_stall_req_o, e.rd, e.val);
        end
        next_cycle(); idle_in(); #1;
        e = pop_exp();
        n_checks++;
        if (rf_rd_store_o !== 1'b1 || {rf_rd_o, rf_rd_value_o} !== e) begin
            n_fail++; $display("FAIL held_instr_capture got st=%b rd=%0d val=%h want 1 %0d %h",
                               rf_rd_store_o, rf_rd_o, rf_rd_value_o, e.rd, e.val);
        end
    endtask

    task automatic test_timeout(input logic done_at_end);
        next_cycle();
        drive(1, 5'd3, 32'h0, 1, 1, 3'b010, 2'd0);
        if (done_at_end) exp_q.push_back(wr_t'{rd: 5'd3, val: 32'hCAFEF00D});
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c == 1) idle_in();
            if (c == 5 && done_at_end) begin dm_done = 1; dm_data = 32'hCAFEF00D; end
            #1;
            n_checks++;
            if (c < 5) begin
                if (w_stall_req_o !== 1'b1 || w_load_fault_o !== 1'b0 || rf_rd_store_o !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_wait cyc=%0d got stall=%b fault=%b st=%b want 1 0 0",
                                       c, w_stall_req_o, w_load_fault_o, rf_rd_store_o);
                end
            end else if (done_at_end) begin
                e = pop_exp();
                if (rf_rd_store_o !== 1'b1 || w_load_fault_o !== 1'b0 || w_stall_req_o !== 1'b0
                    || {rf_rd_o, rf_rd_value_o} !== e) begin
                    n_fail++; $display("FAIL timeout_done_wins got st=%b fault=%b stall=%b val=%h want 1 0 0 %h",
                                       rf_rd_store_o, w_load_fault_o, w_stall_req_o, rf_rd_value_o, e.val);
                end
            end else begin
                if (w_load_fault_o !== 1'b1 || rf_rd_store_o !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_fault got fault=%b st=%b want 1 0",
                                       w_load_fault_o, rf_rd_store_o);
                end
            end
        end
        next_cycle(); dm_done = 0; #1;
        n_checks++;
        if (w_load_fault_o !== 1'b0 || w_stall_req_o !== 1'b0 || rf_rd_store_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after got fault=%b stall=%b st=%b want 0 0 0",
                               w_load_fault_o, w_stall_req_o, rf_rd_store_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        drive(1, 5'd4, 32'h0, 1, 1, 3'b010, 2'd0);
        next_cycle(); idle_in();
        next_cycle(); #1;
        n_checks++;
        if (w_stall_req_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_stall got %b want 1", w_stall_req_o);
        end
        next_cycle(); rst = 1;
        next_cycle(); rst = 0; dm_done = 1; dm_data = 32'hFFFFFFFF; #1;
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin next_cycle(); dm_done = 0; #1; end
            n_checks++;
            if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o, rf_bypass_rd_write_o, rf_bypass_rd_value_o,
                 w_stall_req_o, w_load_fault_o} !== '0) begin
                n_fail++; $display("FAIL rst_mid_wait cyc=%0d got st=%b val=%h stall=%b fault=%b want all 0",
                                   c, rf_rd_store_o, rf_rd_value_o, w_stall_req_o, w_load_fault_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            if (i <= 4) begin
                drive(1, 5'(i + 10), 32'h11111111 * i, 1, 0, 3'b000, 2'd0);
                exp_q.push_back(wr_t'{rd: 5'(i + 10), val: 32'h11111111 * i});
            end else begin
                idle_in();
            end
            #1;
            if (i > 1) begin
                e = pop_exp();
                n_checks++;
                if (rf_rd_store_o !== 1'b1 || {rf_rd_o, rf_rd_value_o} !== e) begin
                    n_fail++; $display("FAIL b2b_%0d got st=%b rd=%0d val=%h want 1 %0d %h",
                                       i - 1, rf_rd_store_o, rf_rd_o, rf_rd_value_o, e.rd, e.val);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_x0();
        test_same_cycle_load(3'b000, 2'd2, 32'h00801234, 32'hFFFFFF80);
        test_same_cycle_load(3'b100, 2'd2, 32'h00801234, 32'h00000080);
        test_same_cycle_load(3'b101, 2'd2, 32'h00801234, 32'h00000080);
        test_same_cycle_load(3'b001, 2'd1, 32'h12348001, 32'hFFFF8001);
        test_same_cycle_load(3'b000, 2'd3, 32'h80000000, 32'hFFFFFF80);
        test_same_cycle_load(3'b111, 2'd1, 32'hA5A55A5A, 32'hA5A55A5A);
        test_delayed_load();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_wait();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drained got %0d left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
